// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, requests instruction memory, and holds a
// 2-entry in-order prefetch queue. Optional FETCH_PERF_EN adds stall/flush counters.
module instr_fetch #(
    parameter int              PC_W     = 16,
    parameter int              INSTR_W  = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [3:0]         opcode,
    output logic [PC_W-1:0]    instr_pc,
    input  logic               jump,
    input  logic               beq,
    input  logic               bne,
    input  logic               zero,
    input  logic [PC_W-1:0]    target_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]        stall_cnt,
    output logic [15:0]        flush_cnt
`endif
);

    typedef enum logic [1:0] {
        BOOT,
        FETCH,
        FLUSH
    } state_t;

    state_t             r_state;
    logic [PC_W-1:0]    r_pc;
    logic [1:0]         r_count;
    logic               r_head;
    logic [INSTR_W-1:0] r_q_instr [2];
    logic [PC_W-1:0]    r_q_pc    [2];

    logic w_taken;
    logic w_redirect;
    logic w_push;
    logic w_pop;
    logic w_wr_idx;

    assign w_taken    = jump | (beq & zero) | (bne & ~zero);
    assign w_redirect = w_taken && (r_state != BOOT);
    assign w_push     = imem_req & imem_ack;
    assign w_pop      = instr_valid & instr_ready;
    assign w_wr_idx   = r_head ^ r_count[0];

    // Both handshake qualifiers decode only registered state, so neither ack nor
    // ready can reach req/valid combinationally.
    assign imem_req    = (r_state == FETCH) && (r_count != 2'd2);
    assign imem_addr   = r_pc;
    assign instr_valid = (r_count != 2'd0) && (r_state != FLUSH);
    assign instr       = r_q_instr[r_head];
    assign opcode      = instr[INSTR_W-1 -: 4];
    assign instr_pc    = r_q_pc[r_head];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= BOOT;
            r_pc    <= RESET_PC;
            r_count <= 2'd0;
            r_head  <= 1'b0;
            // NOTE: the queue storage is reset because the head drives instr/instr_pc,
            // which must read zero out of reset; it is only two entries.
            for (int i = 0; i < 2; i++) begin
                r_q_instr[i] <= '0;
                r_q_pc[i]    <= '0;
            end
        end else if (w_redirect) begin
            // Redirect wins over any same-cycle ack data or pop.
            r_state <= FLUSH;
            r_pc    <= target_pc;
            r_count <= 2'd0;
        end else begin
            // NOTE: non-blocking everywhere here, so every term above sees pre-edge values.
            r_state <= FETCH;
            if (w_push) begin
                r_q_instr[w_wr_idx] <= imem_rdata;
                r_q_pc[w_wr_idx]    <= r_pc;
                r_pc                <= r_pc + PC_W'(2);
            end
            if (w_pop) begin
                r_head <= ~r_head;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

`ifdef FETCH_PERF_EN
    logic [15:0] r_stall_cnt;
    logic [15:0] r_flush_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (imem_req && !imem_ack && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
            if (w_redirect && (r_flush_cnt != 16'hFFFF)) begin
                r_flush_cnt <= r_flush_cnt + 16'd1;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a queue-based reference model checked every cycle,
// plus hand-computed expectations at the interesting points of each scenario.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        ack;
    logic [15:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [3:0]  opcode;
    logic [15:0] instr_pc;
    logic        jump, beq, bne, zero;
    logic [15:0] target_pc;
`ifdef FETCH_PERF_EN
    logic [15:0] stall_cnt, flush_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Memory returns addr | 16'h1000 on the address the DUT presents.
    assign imem_rdata = imem_addr | 16'h1000;

    instr_fetch #(.PC_W(16), .INSTR_W(16), .RESET_PC(16'h0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(ack), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .opcode(opcode), .instr_pc(instr_pc),
        .jump(jump), .beq(beq), .bne(bne), .zero(zero), .target_pc(target_pc)
`ifdef FETCH_PERF_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference model: a plain FIFO of {pc, word}, the next fetch address and two phase flags.
    logic [15:0] mq_pc[$];
    logic [15:0] mq_instr[$];
    logic        m_boot = 1'b1;
    logic        m_flush = 1'b0;
    logic [15:0] m_pc = 16'h0;
    logic [15:0] m_stall = 16'h0;
    logic [15:0] m_fcnt = 16'h0;
    logic        e_req, e_valid, e_taken;
    logic [15:0] e_instr;

    always @(negedge clk) begin
        if (!rst_n) begin
            mq_pc.delete();
            mq_instr.delete();
            m_boot  = 1'b1;
            m_flush = 1'b0;
            m_pc    = 16'h0;
            m_stall = 16'h0;
            m_fcnt  = 16'h0;
            check("rst_req", imem_req, 0);
            check("rst_addr", imem_addr, 0);
            check("rst_valid", instr_valid, 0);
            check("rst_instr", instr, 0);
            check("rst_pc", instr_pc, 0);
            check("rst_opcode", opcode, 0);
`ifdef FETCH_PERF_EN
            check("rst_stall_cnt", stall_cnt, 0);
            check("rst_flush_cnt", flush_cnt, 0);
`endif
        end else begin
            e_req   = !m_boot && !m_flush && (mq_pc.size() < 2);
            e_valid = !m_boot && !m_flush && (mq_pc.size() > 0);
            check("m_req", imem_req, e_req);
            check("m_addr", imem_addr, m_pc);
            check("m_valid", instr_valid, e_valid);
            if (e_valid) begin
                e_instr = mq_instr[0];
                check("m_instr", instr, e_instr);
                check("m_instr_pc", instr_pc, mq_pc[0]);
                check("m_opcode", opcode, e_instr[15:12]);
            end
`ifdef FETCH_PERF_EN
            check("m_stall_cnt", stall_cnt, m_stall);
            check("m_flush_cnt", flush_cnt, m_fcnt);
`endif
            e_taken = jump | (beq & zero) | (bne & ~zero);
            if (e_req && !ack && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
            if (m_boot) begin
                m_boot = 1'b0;
            end else if (e_taken) begin
                mq_pc.delete();
                mq_instr.delete();
                m_pc    = target_pc;
                m_flush = 1'b1;
                if (m_fcnt != 16'hFFFF) m_fcnt = m_fcnt + 16'd1;
            end else begin
                m_flush = 1'b0;
                if (e_valid && instr_ready) begin
                    void'(mq_pc.pop_front());
                    void'(mq_instr.pop_front());
                end
                if (e_req && ack) begin
                    mq_pc.push_back(m_pc);
                    mq_instr.push_back(m_pc | 16'h1000);
                    m_pc = m_pc + 16'd2;
                end
            end
        end
    end

    int pushes;

    initial begin
        rst_n = 1'b0; ack = 1'b1; instr_ready = 1'b1;
        jump = 1'b0; beq = 1'b0; bne = 1'b0; zero = 1'b0; target_pc = 16'h0;
        step(3);
        check("reset_req", imem_req, 0);
        check("reset_addr", imem_addr, 16'h0000);
        check("reset_instr", instr, 16'h0000);
        rst_n = 1'b1;
        check("boot_req_low", imem_req, 0);
        step(1);
        check("first_req", imem_req, 1);
        check("first_addr", imem_addr, 16'h0000);
        step(1);
        check("first_valid", instr_valid, 1);
        check("first_pc", instr_pc, 16'h0000);
        check("first_opcode", opcode, 4'h1);
        step(1);
        check("second_pc", instr_pc, 16'h0002);
        check("second_instr", instr, 16'h1002);
        step(4);

        // Backpressure: restart at 0 and hold decode off for 5 cycles.
        jump = 1'b1; target_pc = 16'h0000; instr_ready = 1'b0;
        step(1);
        jump = 1'b0;
        check("flush_valid", instr_valid, 0);
        check("flush_req", imem_req, 0);
        step(1);
        pushes = 0;
        for (int i = 0; i < 5; i++) begin
            if (imem_req && ack) pushes++;
            step(1);
        end
        check("bp_pushes", pushes, 2);
        check("bp_req", imem_req, 0);
        check("bp_addr", imem_addr, 16'h0004);
        check("bp_head", instr_pc, 16'h0000);
        instr_ready = 1'b1;
        step(4);

        // Branch taken with a full queue.
        instr_ready = 1'b0;
        step(3);
        check("full_req", imem_req, 0);
        beq = 1'b1; zero = 1'b1; target_pc = 16'h0040;
        step(1);
        beq = 1'b0; zero = 1'b0; instr_ready = 1'b1;
        check("beq_flush_valid", instr_valid, 0);
        step(1);
        check("beq_req_addr", imem_addr, 16'h0040);
        check("beq_no_valid", instr_valid, 0);
        step(1);
        check("beq_valid", instr_valid, 1);
        check("beq_pc", instr_pc, 16'h0040);

        // bne with zero=1 is not taken; with zero=0 it redirects.
        bne = 1'b1; zero = 1'b1; target_pc = 16'h0080;
        step(1);
        check("bne_nt_valid", instr_valid, 1);
        check("bne_nt_pc", instr_pc, 16'h0042);
        zero = 1'b0; target_pc = 16'h0100;
        step(1);
        bne = 1'b0;
        check("bne_flush_valid", instr_valid, 0);
        step(1);
        check("bne_addr", imem_addr, 16'h0100);
        step(1);
        check("bne_pc", instr_pc, 16'h0100);
        step(2);

        // Memory stall at the top of the address space, then wrap.
        jump = 1'b1; target_pc = 16'hFFFE;
        step(1);
        jump = 1'b0;
        step(1);
        ack = 1'b0;
        check("stall_addr0", imem_addr, 16'hFFFE);
        step(1);
        check("stall_addr1", imem_addr, 16'hFFFE);
        check("stall_req", imem_req, 1);
        step(1);
        check("stall_addr2", imem_addr, 16'hFFFE);
        step(1);
        ack = 1'b1;
        check("stall_addr3", imem_addr, 16'hFFFE);
        step(1);
        check("wrap_addr", imem_addr, 16'h0000);
        check("wrap_pc", instr_pc, 16'hFFFE);
        step(3);

`ifdef FETCH_PERF_EN
        check("perf_stall", stall_cnt, 16'd3);
        check("perf_flush", flush_cnt, 16'd4);
`endif
        // Asynchronous reset mid-stream.
        rst_n = 1'b0;
        #1;
        check("arst_req", imem_req, 0);
        check("arst_valid", instr_valid, 0);
        check("arst_addr", imem_addr, 16'h0000);
        check("arst_pc", instr_pc, 16'h0000);
`ifdef FETCH_PERF_EN
        check("arst_stall", stall_cnt, 16'd0);
        check("arst_flush", flush_cnt, 16'd0);
`endif
        step(2);
        rst_n = 1'b1;
        check("rerun_boot", imem_req, 0);
        step(1);
        check("rerun_req", imem_req, 1);
        check("rerun_addr", imem_addr, 16'h0000);
        step(1);
        check("rerun_pc", instr_pc, 16'h0000);
        step(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
